// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and helpers for the memory responder.
//   size_e  - access size encoding as carried on size_i
//   state_e - responder FSM states
//   byte_en - byte-lane write mask for a given access size and lane
package mem_responder_pkg;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Halves only ever sit in the low or high pair of lanes; anything wider
  // than a half (including the illegal code) enables all four lanes.
  function automatic logic [3:0] byte_en(size_e size, logic [1:0] lane);
    case (size)
      SizeByte: return 4'b0001 << lane;
      SizeHalf: return lane[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_ram_be.sv
// ram_be: NPos x XLen word array with four byte-lane write enables.
// Write and read are both synchronous and share one enable; a read updates
// rdata on the enabled edge and rdata holds its value otherwise.
// Ports:
//   clk   - clock
//   en    - access enable for this cycle
//   we    - 1 = write selected lanes, 0 = read the word
//   be    - byte-lane write enables
//   idx   - word index
//   wdata - write data (lane i in bits [8i+7:8i])
//   rdata - registered read data
module ram_be #(
  parameter int XLen = 32,
  parameter int NPos = 1024,
  localparam int IdxW = $clog2(NPos)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [IdxW-1:0] idx,
  input  logic [XLen-1:0] wdata,
  output logic [XLen-1:0] rdata
);

  logic [XLen-1:0] mem [NPos];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder for the RV32I core.
// Accepts one request over req/gnt, waits WaitStates extra cycles, performs a
// byte/half/word access on a byte-enabled array and returns one rvalid strobe
// with extended load data.
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned
// halves/words and the illegal size as errors; otherwise err_o is 0,
// misaligned addresses are aligned down and the illegal size acts as word.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   req_i, gnt_o          - request / grant handshake
//   we_i, addr_i, size_i  - store flag, byte address, access size
//   unsigned_i, wdata_i   - load zero-extension select, right-aligned store data
//   rvalid_o, rdata_o, err_o - response strobe, load data, access error
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int XLen       = 32,
  parameter int NPos       = 1024,
  parameter int WaitStates = 1,
  localparam int AddrWidth = $clog2(NPos) + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [XLen-1:0]      wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [XLen-1:0]      rdata_o,
  output logic                 err_o
);

  localparam logic [3:0] WaitLast = 4'(WaitStates);

  state_e                 state;
  logic [3:0]             wait_cnt;
  logic                   we_q, uns_q, err_q;
  size_e                  size_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [XLen-1:0]        wdata_q;
  logic [XLen-1:0]        rdata_hold;
  logic [XLen-1:0]        ram_q;
  logic [XLen-1:0]        resp_data;
  size_e                  req_size;
  logic [AddrWidth-1:0]   req_addr;
  logic                   req_err;
  logic                   mem_en;

  function automatic logic [XLen-1:0] replicate(size_e s, logic [XLen-1:0] d);
    case (s)
      SizeByte: return {4{d[7:0]}};
      SizeHalf: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

  function automatic logic [XLen-1:0] extend_load(logic [XLen-1:0] word,
                                                  logic [1:0] lane,
                                                  size_e s, logic uns);
    logic [XLen-1:0]    sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (s)
      SizeByte: return uns ? XLen'(sh[7:0])  : XLen'(b);
      SizeHalf: return uns ? XLen'(sh[15:0]) : XLen'(h);
      default:  return sh;
    endcase
  endfunction

  // Request decode: either flag misalignment or fold it away before latching,
  // so the access stage only ever sees a legal size and aligned lane.
  always_comb begin
    req_size = size_e'(size_i);
    req_addr = addr_i;
    req_err  = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    case (req_size)
      SizeHalf:    req_err = addr_i[0];
      SizeWord:    req_err = |addr_i[1:0];
      SizeIllegal: req_err = 1'b1;
      default:     req_err = 1'b0;
    endcase
`else
    if (req_size == SizeIllegal) req_size = SizeWord;
    if (req_size == SizeHalf) req_addr[0] = 1'b0;
    if (req_size == SizeWord) req_addr[1:0] = 2'b00;
`endif
  end

  assign gnt_o    = (state == IDLE) && !rst_i;
  assign rvalid_o = (state == RESP);

  // Gating with !rst_i drops a store whose enable cycle coincides with reset.
  assign mem_en = (state == ACCESS) && (wait_cnt == WaitLast) && !err_q && !rst_i;

  ram_be #(.XLen(XLen), .NPos(NPos)) u_ram (
    .clk   (clk_i),
    .en    (mem_en),
    .we    (we_q),
    .be    (byte_en(size_q, addr_q[1:0])),
    .idx   (addr_q[AddrWidth-1:2]),
    .wdata (replicate(size_q, wdata_q)),
    .rdata (ram_q)
  );

  assign resp_data = (we_q || err_q) ? '0 : extend_load(ram_q, addr_q[1:0], size_q, uns_q);

  // The array read lands at the start of RESP, so the response word is
  // formed from it there and captured into rdata_hold for the idle period.
  assign rdata_o = (state == RESP) ? resp_data : rdata_hold;

  // Request capture (data only, not reset)
  always_ff @(posedge clk_i) begin
    if (req_i && gnt_o) begin
      we_q    <= we_i;
      uns_q   <= unsigned_i;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= wdata_i;
      err_q   <= req_err;
    end
  end

  // Control FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            state    <= ACCESS;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (wait_cnt == WaitLast) state <= RESP;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        RESP: begin
          state      <= IDLE;
          rdata_hold <= resp_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic err_hold;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_hold <= 1'b0;
    else if (state == RESP) err_hold <= err_q;
  end

  assign err_o = (state == RESP) ? err_q : err_hold;
`else
  assign err_o = 1'b0;
`endif

endmodule
